// File: rtl/vector_buffer_pkg.sv
// Shared types for the vector_buffer slice: controller states and decoded commands.
package vector_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_INSERT_SHIFT = 2'd1,
        ST_REMOVE_SHIFT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_GET    = 2'd1,
        CMD_INSERT = 2'd2,
        CMD_REMOVE = 2'd3
    } cmd_e;

endpackage

// File: rtl/vector_buffer_ram.sv
// Element storage: one combinational read port and one synchronous write port.
module vector_buffer_ram #(
    parameter int DATA_WIDTH = 7,
    parameter int DATA_COUNT = 127,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // Contents are never reset; positions at or beyond the length are don't-care.
    logic [DATA_WIDTH-1:0] mem_q [DATA_COUNT];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vector_buffer.sv
// Ordered, length-tracked element store with positional insert/remove (tail shifted
// one element per cycle) and registered random-access read.
module vector_buffer
    import vector_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH   = 7,
    parameter  int DATA_COUNT   = 127,
    localparam int INDEX_WIDTH  = $clog2(DATA_COUNT),
    localparam int LENGTH_WIDTH = $clog2(DATA_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic                    get,
    input  logic                    insert,
    input  logic                    remove,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [LENGTH_WIDTH-1:0] length,
    output logic                    ready
);

    state_e                  state_q, state_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [INDEX_WIDTH-1:0]  ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;

    logic                    wr_en;
    logic [INDEX_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [INDEX_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;

    cmd_e                    cmd;
    logic [LENGTH_WIDTH-1:0] index_ext;
    logic [LENGTH_WIDTH-1:0] ptr_inc;
    logic                    rem_ok, ins_ok, ins_last, rem_last;

    always_comb begin
        if (remove)      cmd = CMD_REMOVE;
        else if (insert) cmd = CMD_INSERT;
        else if (get)    cmd = CMD_GET;
        else             cmd = CMD_NONE;
    end

    assign index_ext = LENGTH_WIDTH'(index);
    assign ptr_inc   = LENGTH_WIDTH'(ptr_q) + LENGTH_WIDTH'(1);
    assign rem_ok    = (cmd == CMD_REMOVE) && (index_ext < len_q);
    assign ins_ok    = (cmd == CMD_INSERT) && (len_q < LENGTH_WIDTH'(DATA_COUNT))
                       && (index_ext <= len_q);
    // Insert walks ptr down from the old length; remove walks it up from the index.
    assign ins_last  = (ptr_q == idx_q);
    assign rem_last  = (ptr_inc >= len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
        idx_q <= idx_d;
        din_q <= din_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rem_ok)      state_d = ST_REMOVE_SHIFT;
                else if (ins_ok) state_d = ST_INSERT_SHIFT;
            end
            ST_INSERT_SHIFT: if (ins_last) state_d = ST_IDLE;
            ST_REMOVE_SHIFT: if (rem_last) state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        dout_d  = dout_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        din_d   = din_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = rd_data;
        rd_addr = index;
        case (state_q)
            ST_IDLE: begin
                if (rem_ok) begin
                    ptr_d = index;
                end else if (ins_ok) begin
                    ptr_d = INDEX_WIDTH'(len_q);
                    idx_d = index;
                    din_d = data_in;
                end else if (cmd == CMD_GET) begin
                    dout_d = (index_ext < len_q) ? rd_data : '0;
                end
            end
            ST_INSERT_SHIFT: begin
                wr_en = 1'b1;
                if (ins_last) begin
                    wr_addr = idx_q;
                    wr_data = din_q;
                    len_d   = len_q + LENGTH_WIDTH'(1);
                end else begin
                    rd_addr = ptr_q - INDEX_WIDTH'(1);
                    ptr_d   = ptr_q - INDEX_WIDTH'(1);
                end
            end
            ST_REMOVE_SHIFT: begin
                if (rem_last) begin
                    len_d = len_q - LENGTH_WIDTH'(1);
                end else begin
                    wr_en   = 1'b1;
                    rd_addr = INDEX_WIDTH'(ptr_inc);
                    ptr_d   = INDEX_WIDTH'(ptr_inc);
                end
            end
            default: ;
        endcase
    end

    vector_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_COUNT (DATA_COUNT),
        .ADDR_WIDTH (INDEX_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign data_out = dout_q;
    assign length   = len_q;
    assign ready    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_vector_buffer.sv
// Directed bench for vector_buffer (DATA_COUNT=4) with a queue-based reference model.
module tb_vector_buffer;

    localparam int DW = 7;
    localparam int DC = 4;
    localparam int IW = $clog2(DC);
    localparam int LW = $clog2(DC + 1);

    localparam logic [DW-1:0] CH_A = 7'h61;
    localparam logic [DW-1:0] CH_B = 7'h62;
    localparam logic [DW-1:0] CH_C = 7'h63;
    localparam logic [DW-1:0] CH_D = 7'h64;
    localparam logic [DW-1:0] CH_E = 7'h65;
    localparam logic [DW-1:0] CH_F = 7'h66;
    localparam logic [DW-1:0] CH_H = 7'h68;
    localparam logic [DW-1:0] CH_I = 7'h69;
    localparam logic [DW-1:0] CH_Q = 7'h71;
    localparam logic [DW-1:0] CH_Z = 7'h7a;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] index = '0;
    logic          get = 1'b0;
    logic          insert = 1'b0;
    logic          remove = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [LW-1:0] length;
    logic          ready;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // Reference model: list contents, pending edit and remaining busy cycles.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout = '0;
    int            m_busy = 0;
    bit            m_rem = 1'b0;
    int            m_idx = 0;
    logic [DW-1:0] m_data = '0;

    always #5 clk = ~clk;

    vector_buffer #(
        .DATA_WIDTH (DW),
        .DATA_COUNT (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .index    (index),
        .get      (get),
        .insert   (insert),
        .remove   (remove),
        .data_in  (data_in),
        .data_out (data_out),
        .length   (length),
        .ready    (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int i;
        i = int'(index);
        if (rst) begin
            m_q.delete();
            m_busy = 0;
            m_dout = '0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                if (m_rem) m_q.delete(m_idx);
                else       m_q.insert(m_idx, m_data);
            end
        end else if (remove) begin
            if (i < m_q.size()) begin
                m_busy = m_q.size() - i;
                m_rem  = 1'b1;
                m_idx  = i;
            end
        end else if (insert) begin
            if (m_q.size() < DC && i <= m_q.size()) begin
                m_busy = m_q.size() - i + 1;
                m_rem  = 1'b0;
                m_idx  = i;
                m_data = data_in;
            end
        end else if (get) begin
            m_dout = (i < m_q.size()) ? m_q[i] : '0;
        end
    endtask

    task automatic cyc(input bit r, input int idx, input bit g, input bit ins, input bit rem,
                       input logic [DW-1:0] d);
        rst = r; index = IW'(idx); get = g; insert = ins; remove = rem; data_in = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 1'b0; get = 1'b0; insert = 1'b0; remove = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            idle();
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic do_get(input int idx, input string name, input logic [DW-1:0] exp);
        cyc(1'b0, idx, 1'b1, 1'b0, 1'b0, '0);
        check(name, 32'(data_out), 32'(exp));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready", 32'(ready), (m_busy == 0) ? 32'd1 : 32'd0);
            check("cyc_length", 32'(length), 32'(m_q.size()));
            check("cyc_data_out", 32'(data_out), 32'(m_dout));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, '0);
        chk_en = 1'b1;
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, '0);
        idle();
        check("rst_length", 32'(length), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        do_get(0, "get_empty", '0);

        // Build [a,c,b]
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, CH_A); wait_ready(n); check("ins_a_busy", 32'(n), 32'd1);
        cyc(1'b0, 1, 1'b0, 1'b1, 1'b0, CH_B); wait_ready(n); check("ins_b_busy", 32'(n), 32'd1);
        cyc(1'b0, 1, 1'b0, 1'b1, 1'b0, CH_C); wait_ready(n); check("ins_c_busy", 32'(n), 32'd2);
        check("len_3", 32'(length), 32'd3);
        do_get(0, "get0_a", CH_A);
        do_get(1, "get1_c", CH_C);
        do_get(2, "get2_b", CH_B);
        do_get(3, "get3_end", '0);

        // Remove head, then an out-of-range remove
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, '0); wait_ready(n); check("rem0_busy", 32'(n), 32'd3);
        check("len_2", 32'(length), 32'd2);
        do_get(0, "after_rem_get0", CH_C);
        do_get(1, "after_rem_get1", CH_B);
        cyc(1'b0, 2, 1'b0, 1'b0, 1'b1, '0);
        check("rem_oob_ready", 32'(ready), 32'd1);
        check("rem_oob_len", 32'(length), 32'd2);

        // Fill to capacity: [d,c,e,b]
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, CH_D); wait_ready(n); check("ins_d_busy", 32'(n), 32'd3);
        cyc(1'b0, 2, 1'b0, 1'b1, 1'b0, CH_E); wait_ready(n); check("ins_e_busy", 32'(n), 32'd2);
        check("len_full", 32'(length), 32'd4);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, CH_F);
        check("ins_full_ready", 32'(ready), 32'd1);
        check("ins_full_len", 32'(length), 32'd4);
        do_get(0, "full_get0", CH_D);
        do_get(2, "full_get2", CH_E);
        cyc(1'b0, 3, 1'b0, 1'b0, 1'b1, '0); wait_ready(n); check("rem_last_busy", 32'(n), 32'd1);
        check("len_after_rem_last", 32'(length), 32'd3);

        // insert and remove together: only the remove happens -> [c,e]
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1, CH_Z); wait_ready(n); check("both_busy", 32'(n), 32'd3);
        check("both_len", 32'(length), 32'd2);
        do_get(0, "both_get0", CH_C);
        do_get(1, "both_get1", CH_E);

        // get while busy is ignored -> data_out still 'e'; result [h,c,e]
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, CH_H);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, '0);
        check("busy_get_ignored", 32'(data_out), 32'(CH_E));
        wait_ready(n); check("ins_h_rest", 32'(n), 32'd2);
        do_get(0, "get0_h", CH_H);
        do_get(2, "get2_e", CH_E);

        // Reset in the middle of a 4-cycle shift
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, CH_I);
        idle();
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, '0);
        check("midrst_len", 32'(length), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_dout", 32'(data_out), 32'd0);

        // Dropped commands on an empty buffer
        cyc(1'b0, 2, 1'b0, 1'b1, 1'b0, CH_Q);
        check("ins_gap_ready", 32'(ready), 32'd1);
        check("ins_gap_len", 32'(length), 32'd0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, '0);
        check("rem_empty_ready", 32'(ready), 32'd1);
        check("rem_empty_len", 32'(length), 32'd0);

        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, CH_Q); wait_ready(n); check("ins_q_busy", 32'(n), 32'd1);
        do_get(0, "get0_q", CH_Q);
        do_get(1, "get1_end", '0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
